// File: rtl/fir_coeff_ctrl_if.sv
// Coefficient stream, FIR coefficient-memory port and status signals of fir_coeff_ctrl.
// master = config source / memory side, slave = the controller.
`timescale 1ns/1ps
interface fir_coeff_ctrl_if #(
    parameter int DW = 12,
    parameter int AW = 8
);
    logic          cfg_start;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_data;
    logic          cfg_last;
    logic          fir_hlt;
    logic          fir_load;
    logic [AW-1:0] fir_write_address;
    logic [DW-1:0] fir_write_value;
    logic [AW-1:0] fir_read_address;
    logic [DW-1:0] fir_read_value;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   tap_count;

    modport master (
        output cfg_start, cfg_valid, cfg_data, cfg_last, fir_read_value,
        input  cfg_ready, fir_hlt, fir_load, fir_write_address, fir_write_value,
               fir_read_address, busy, done, err, tap_count
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, cfg_last, fir_read_value,
        output cfg_ready, fir_hlt, fir_load, fir_write_address, fir_write_value,
               fir_read_address, busy, done, err, tap_count
    );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient programmer: stream write, zero-fill, checksum readback, then release fir_hlt.
// One registered write per accepted beat; cfg_ready is high only in WRITE until NTAPS beats are taken.
`timescale 1ns/1ps
module fir_coeff_ctrl #(
    parameter int NTAPS  = 16,
    parameter int DW     = 12,
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic             Clk,
    input  logic             Hlt,
    fir_coeff_ctrl_if.slave  bus
);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(NTAPS - 1);
    localparam logic [CW-1:0] NT   = CW'(NTAPS);

    typedef enum logic [2:0] {
        UNCFG,
        RUN,
        WRITE,
        FILL,
        VERIFY
    } state_t;

    state_t        state;
    logic [CW-1:0] wptr;
    logic [CW-1:0] ridx;
    logic [CW-1:0] ccnt;
    logic [15:0]   wsum;
    logic [15:0]   rsum;
    logic [RD_LAT:0] rd_pipe;
    logic          beat;

    assign beat = (state == WRITE) && bus.cfg_valid && bus.cfg_ready;

    always_ff @(posedge Clk or posedge Hlt) begin
        if (Hlt) begin
            state                 <= UNCFG;
            wptr                  <= '0;
            ridx                  <= '0;
            ccnt                  <= '0;
            wsum                  <= '0;
            rsum                  <= '0;
            rd_pipe               <= '0;
            bus.cfg_ready         <= 1'b0;
            bus.fir_hlt           <= 1'b1;
            bus.fir_load          <= 1'b0;
            bus.fir_write_address <= '0;
            bus.fir_write_value   <= '0;
            bus.fir_read_address  <= '0;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
            bus.err               <= 1'b0;
            bus.tap_count         <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.fir_load <= 1'b0;
            // rd_pipe[k] marks a readback address issued k cycles ago
            for (int i = RD_LAT; i > 0; i--) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            rd_pipe[0] <= 1'b0;

            case (state)
                UNCFG, RUN: begin
                    if (bus.cfg_start) begin
                        state         <= WRITE;
                        bus.cfg_ready <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.fir_hlt   <= 1'b1;
                        bus.err       <= 1'b0;
                        bus.tap_count <= '0;
                        wptr          <= '0;
                        ridx          <= '0;
                        ccnt          <= '0;
                        wsum          <= '0;
                        rsum          <= '0;
                    end
                end

                WRITE: begin
                    if (beat) begin
                        bus.fir_load          <= 1'b1;
                        bus.fir_write_address <= wptr[AW-1:0];
                        bus.fir_write_value   <= bus.cfg_data;
                        bus.tap_count         <= wptr + 1'b1;
                        wsum                  <= wsum + 16'(bus.cfg_data);
                        wptr                  <= wptr + 1'b1;
                        if (wptr == LAST) begin
                            // A full-length stream without cfg_last is an overflow; still verified
                            bus.cfg_ready <= 1'b0;
                            state         <= VERIFY;
                            if (!bus.cfg_last) begin
                                bus.err <= 1'b1;
                            end
                        end else if (bus.cfg_last) begin
                            bus.cfg_ready <= 1'b0;
                            state         <= FILL;
                        end
                    end
                end

                FILL: begin
                    bus.fir_load          <= 1'b1;
                    bus.fir_write_address <= wptr[AW-1:0];
                    bus.fir_write_value   <= '0;
                    wptr                  <= wptr + 1'b1;
                    if (wptr == LAST) begin
                        state <= VERIFY;
                    end
                end

                VERIFY: begin
                    if (ridx != NT) begin
                        bus.fir_read_address <= ridx[AW-1:0];
                        ridx                 <= ridx + 1'b1;
                        rd_pipe[0]           <= 1'b1;
                    end
                    if (rd_pipe[RD_LAT]) begin
                        rsum <= rsum + 16'(bus.fir_read_value);
                        ccnt <= ccnt + 1'b1;
                    end else if (ccnt == NT) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        if ((rsum == wsum) && !bus.err) begin
                            state       <= RUN;
                            bus.fir_hlt <= 1'b0;
                        end else begin
                            state   <= UNCFG;
                            bus.err <= 1'b1;
                        end
                    end
                end

                default: state <= UNCFG;
            endcase
        end
    end
endmodule
